// File: rtl/stdp_pkg.sv
// Shared definitions for the LIF neuron and the STDP block it feeds:
// default datapath width, spike/weight widths and the neuron state encoding.
package stdp_pkg;

    // Default membrane / weight / threshold width.
    localparam int WIDTH_DEF = 8;

    // Spike and weight widths shared with the STDP block.
    localparam int SPIKE_W   = 1;
    localparam int WEIGHT_W  = WIDTH_DEF;

    // Refractory counter width (REFRACT_CYCLES is limited to 0..255).
    localparam int REFRACT_CNT_W = 8;

    // Neuron FSM state, 2-bit encoding.
    typedef enum logic [1:0] {
        INTEGRATE = 2'd0,
        FIRE      = 2'd1,
        REFRACT   = 2'd2
    } neuron_state_t;

endpackage

// File: rtl/lif_neuron_if.sv
// Spike / weight bundle between the STDP stage and the LIF neuron.
//
// Handshake: there is no valid/ready pair and no backpressure. pre_spike is a
// per-cycle strobe that qualifies weight; both are sampled on every rising
// clk edge. post_spike is a registered one-cycle strobe; membrane and
// refractory are registered status outputs valid every cycle.
interface lif_neuron_if #(
    parameter int WIDTH = stdp_pkg::WIDTH_DEF
);
    logic             pre_spike;
    logic [WIDTH-1:0] weight;
    logic             post_spike;
    logic [WIDTH-1:0] membrane;
    logic             refractory;

    // Driver side (STDP block / testbench).
    modport master (
        output pre_spike,
        output weight,
        input  post_spike,
        input  membrane,
        input  refractory
    );

    // Neuron side.
    modport slave (
        input  pre_spike,
        input  weight,
        output post_spike,
        output membrane,
        output refractory
    );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron. Integrates the synaptic weight on each
// pre-synaptic spike, leaks v >> LEAK_SHIFT every cycle, fires a one-cycle
// post_spike on threshold crossing and then holds off for REFRACT_CYCLES.
module lif_neuron
    import stdp_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int THRESHOLD      = 64,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    lif_neuron_if.slave   nrn,
    output neuron_state_t o_state
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);
    localparam logic [REFRACT_CNT_W-1:0] REFRACT_INIT =
        (REFRACT_CYCLES > 0) ? REFRACT_CNT_W'(REFRACT_CYCLES - 1) : '0;

    neuron_state_t            r_state;
    neuron_state_t            w_state_next;
    logic [WIDTH-1:0]         r_v;
    logic [WIDTH-1:0]         w_v_next;
    logic [REFRACT_CNT_W-1:0] r_cnt;
    logic [REFRACT_CNT_W-1:0] w_cnt_next;
    logic                     r_post;
    logic                     r_refr;

    // One guard bit so leak + weight can never wrap before saturation.
    logic [WIDTH:0]           w_v_ext;
    logic [WIDTH:0]           w_leaked;
    logic [WIDTH:0]           w_add;
    logic [WIDTH:0]           w_sum;
    logic [WIDTH-1:0]         w_sat;

    // Integration datapath: leak, add weight on spike, saturate to all-ones.
    always_comb begin
        w_v_ext  = {1'b0, r_v};
        w_leaked = w_v_ext - (w_v_ext >> LEAK_SHIFT);
        w_add    = nrn.pre_spike ? {1'b0, nrn.weight} : '0;
        w_sum    = w_leaked + w_add;
        w_sat    = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end

    // Next-state, next-membrane and refractory counter decisions.
    always_comb begin
        w_state_next = r_state;
        w_v_next     = r_v;
        w_cnt_next   = r_cnt;
        case (r_state)
            INTEGRATE: begin
                // Compare the saturated value so overflow always fires.
                if (w_sat >= THR) begin
                    w_state_next = FIRE;
                    w_v_next     = '0;
                end else begin
                    w_v_next     = w_sat;
                end
            end
            FIRE: begin
                w_v_next = '0;
                if (REFRACT_CYCLES == 0) begin
                    w_state_next = INTEGRATE;
                end else begin
                    w_state_next = REFRACT;
                    w_cnt_next   = REFRACT_INIT;
                end
            end
            REFRACT: begin
                // Inputs are ignored; counter reaching 0 ends the hold-off.
                w_v_next = '0;
                if (r_cnt == '0) begin
                    w_state_next = INTEGRATE;
                end else begin
                    w_cnt_next   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = INTEGRATE;
                w_v_next     = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, membrane and registered output flags; reset wins in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INTEGRATE;
            r_v     <= '0;
            r_cnt   <= '0;
            r_post  <= 1'b0;
            r_refr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_v     <= w_v_next;
            r_cnt   <= w_cnt_next;
            r_post  <= (w_state_next == FIRE);
            r_refr  <= (w_state_next == REFRACT);
        end
    end

    assign nrn.post_spike = r_post;
    assign nrn.refractory = r_refr;
    assign nrn.membrane   = r_v;
    assign o_state        = r_state;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron: one instance with REFRACT_CYCLES=4 and
// one with REFRACT_CYCLES=0. Observed tuple is {post_spike, refractory, membrane}.
module tb_lif_neuron;
    import stdp_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lif_neuron_if #(.WIDTH(W)) bus_a ();
    lif_neuron_if #(.WIDTH(W)) bus_b ();
    neuron_state_t state_a;
    neuron_state_t state_b;

    lif_neuron #(.WIDTH(W), .THRESHOLD(64), .LEAK_SHIFT(3), .REFRACT_CYCLES(4)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .nrn     (bus_a.slave),
        .o_state (state_a)
    );

    lif_neuron #(.WIDTH(W), .THRESHOLD(64), .LEAK_SHIFT(3), .REFRACT_CYCLES(0)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .nrn     (bus_b.slave),
        .o_state (state_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus_a.pre_spike = 1'b0;
        bus_a.weight    = '0;
        bus_b.pre_spike = 1'b0;
        bus_b.weight    = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd255;
        bus_b.pre_spike = 1'b1;
        bus_b.weight    = 8'd255;
        tick();
        tick();
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== 10'd0 || state_a !== INTEGRATE) begin
            n_err++;
            $display("FAIL reset_a: got post=%0b refr=%0b mem=%0d st=%0d, want 0 0 0 st=0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane, state_a);
        end
        n_vec++;
        if ({bus_b.post_spike, bus_b.refractory, bus_b.membrane} !== 10'd0 || state_b !== INTEGRATE) begin
            n_err++;
            $display("FAIL reset_b: got post=%0b refr=%0b mem=%0d st=%0d, want 0 0 0 st=0",
                     bus_b.post_spike, bus_b.refractory, bus_b.membrane, state_b);
        end
        do_reset();
    endtask

    task automatic test_single_fire();
        logic [9:0] exp_t [6];
        exp_t = '{10'b1_0_00000000, 10'b0_1_00000000, 10'b0_1_00000000,
                  10'b0_1_00000000, 10'b0_1_00000000, 10'b0_0_00000000};
        do_reset();
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd64;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus_a.pre_spike = 1'b0;
            n_vec++;
            if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== exp_t[i]) begin
                n_err++;
                $display("FAIL single_fire[%0d]: got post=%0b refr=%0b mem=%0d, want post=%0b refr=%0b mem=%0d",
                         i, bus_a.post_spike, bus_a.refractory, bus_a.membrane,
                         exp_t[i][9], exp_t[i][8], exp_t[i][7:0]);
            end
        end
        n_vec++;
        if (state_a !== INTEGRATE) begin
            n_err++;
            $display("FAIL single_fire_state: got %0d, want %0d", state_a, INTEGRATE);
        end
    endtask

    task automatic test_leak();
        logic [7:0] exp_m [5];
        exp_m = '{8'd40, 8'd35, 8'd31, 8'd28, 8'd25};
        do_reset();
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd40;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus_a.pre_spike = 1'b0;
            n_vec++;
            if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b00, exp_m[i]}) begin
                n_err++;
                $display("FAIL leak[%0d]: got post=%0b refr=%0b mem=%0d, want post=0 refr=0 mem=%0d",
                         i, bus_a.post_spike, bus_a.refractory, bus_a.membrane, exp_m[i]);
            end
        end
        // Spike with zero weight is a plain leak step: 25 - 3 = 22.
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd0;
        tick();
        bus_a.pre_spike = 1'b0;
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b00, 8'd22}) begin
            n_err++;
            $display("FAIL zero_weight: got post=%0b refr=%0b mem=%0d, want 0 0 22",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
    endtask

    task automatic test_accumulate();
        do_reset();
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd40;
        tick();
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b00, 8'd40}) begin
            n_err++;
            $display("FAIL accumulate_first: got post=%0b refr=%0b mem=%0d, want 0 0 40",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
        tick();
        bus_a.pre_spike = 1'b0;
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b10, 8'd0}) begin
            n_err++;
            $display("FAIL accumulate_fire: got post=%0b refr=%0b mem=%0d, want 1 0 0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd60;
        tick();
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b00, 8'd60}) begin
            n_err++;
            $display("FAIL saturation_pre: got post=%0b refr=%0b mem=%0d, want 0 0 60",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
        // 60 - 7 + 255 = 308 saturates to 255 and must fire (a wrap would give 52).
        bus_a.weight = 8'd255;
        tick();
        bus_a.pre_spike = 1'b0;
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b10, 8'd0}) begin
            n_err++;
            $display("FAIL saturation_fire: got post=%0b refr=%0b mem=%0d, want 1 0 0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
    endtask

    task automatic test_refract_ignore();
        logic [9:0] exp_t [8];
        int         fire_idx [$];
        exp_t = '{10'b1_0_00000000, 10'b0_1_00000000, 10'b0_1_00000000, 10'b0_1_00000000,
                  10'b0_1_00000000, 10'b0_0_00000000, 10'b1_0_00000000, 10'b0_1_00000000};
        do_reset();
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd255;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_a.post_spike === 1'b1) fire_idx.push_back(i);
            n_vec++;
            if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== exp_t[i]) begin
                n_err++;
                $display("FAIL refract_ignore[%0d]: got post=%0b refr=%0b mem=%0d, want post=%0b refr=%0b mem=%0d",
                         i, bus_a.post_spike, bus_a.refractory, bus_a.membrane,
                         exp_t[i][9], exp_t[i][8], exp_t[i][7:0]);
            end
        end
        bus_a.pre_spike = 1'b0;
        n_vec++;
        if (fire_idx.size() != 2 || (fire_idx[1] - fire_idx[0]) != 6) begin
            n_err++;
            $display("FAIL refract_spacing: got %0d pulses, want 2 pulses 6 cycles apart", fire_idx.size());
        end
    endtask

    task automatic test_reset_mid_refract();
        do_reset();
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd64;
        tick();
        bus_a.pre_spike = 1'b0;
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b10, 8'd0}) begin
            n_err++;
            $display("FAIL mid_refract_fire: got post=%0b refr=%0b mem=%0d, want 1 0 0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
        tick();
        tick();
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b01, 8'd0}) begin
            n_err++;
            $display("FAIL mid_refract_2nd: got post=%0b refr=%0b mem=%0d, want 0 1 0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== 10'd0 || state_a !== INTEGRATE) begin
            n_err++;
            $display("FAIL mid_refract_reset: got post=%0b refr=%0b mem=%0d st=%0d, want 0 0 0 st=0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane, state_a);
        end
        bus_a.pre_spike = 1'b1;
        bus_a.weight    = 8'd64;
        tick();
        bus_a.pre_spike = 1'b0;
        n_vec++;
        if ({bus_a.post_spike, bus_a.refractory, bus_a.membrane} !== {2'b10, 8'd0}) begin
            n_err++;
            $display("FAIL mid_refract_refire: got post=%0b refr=%0b mem=%0d, want 1 0 0",
                     bus_a.post_spike, bus_a.refractory, bus_a.membrane);
        end
    endtask

    task automatic test_zero_refract();
        logic [9:0] exp_t [5];
        int         fire_idx [$];
        exp_t = '{10'b1_0_00000000, 10'b0_0_00000000, 10'b1_0_00000000,
                  10'b0_0_00000000, 10'b1_0_00000000};
        do_reset();
        bus_b.pre_spike = 1'b1;
        bus_b.weight    = 8'd255;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_b.post_spike === 1'b1) fire_idx.push_back(i);
            n_vec++;
            if ({bus_b.post_spike, bus_b.refractory, bus_b.membrane} !== exp_t[i]) begin
                n_err++;
                $display("FAIL zero_refract[%0d]: got post=%0b refr=%0b mem=%0d, want post=%0b refr=%0b mem=%0d",
                         i, bus_b.post_spike, bus_b.refractory, bus_b.membrane,
                         exp_t[i][9], exp_t[i][8], exp_t[i][7:0]);
            end
        end
        n_vec++;
        if (fire_idx.size() != 3 || (fire_idx[1] - fire_idx[0]) != 2 || (fire_idx[2] - fire_idx[1]) != 2) begin
            n_err++;
            $display("FAIL zero_refract_spacing: got %0d pulses, want 3 pulses 2 cycles apart", fire_idx.size());
        end
        // Reset while in FIRE, with the spike still asserted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_b.pre_spike = 1'b0;
        n_vec++;
        if ({bus_b.post_spike, bus_b.refractory, bus_b.membrane} !== 10'd0 || state_b !== INTEGRATE) begin
            n_err++;
            $display("FAIL zero_refract_reset: got post=%0b refr=%0b mem=%0d st=%0d, want 0 0 0 st=0",
                     bus_b.post_spike, bus_b.refractory, bus_b.membrane, state_b);
        end
        bus_b.pre_spike = 1'b1;
        bus_b.weight    = 8'd64;
        tick();
        bus_b.pre_spike = 1'b0;
        n_vec++;
        if ({bus_b.post_spike, bus_b.refractory, bus_b.membrane} !== {2'b10, 8'd0}) begin
            n_err++;
            $display("FAIL zero_refract_refire: got post=%0b refr=%0b mem=%0d, want 1 0 0",
                     bus_b.post_spike, bus_b.refractory, bus_b.membrane);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus_a.pre_spike = 1'b0;
        bus_a.weight    = '0;
        bus_b.pre_spike = 1'b0;
        bus_b.weight    = '0;
        test_reset();
        test_single_fire();
        test_leak();
        test_accumulate();
        test_saturation();
        test_refract_ignore();
        test_reset_mid_refract();
        test_zero_refract();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
